// File: rtl/tx_serializer_10b.sv
// -----------------------------------------------------------------------------
// tx_serializer_10b
//
// Purpose:
//   Output stage behind the 8b/10b encoder. It takes one encoded symbol at a
//   time over a valid/ready handshake and shifts it out MSB first, which is
//   bit 'a' of the {a,b,c,d,e,i,f,g,h,j} ordering. It keeps the running
//   disparity of the transmitted stream. A one-entry hold register sits in
//   front of the shifter, so the next symbol follows the current one with no
//   gap bit.
//
// Optional feature (macro COMMA_IDLE_EN):
//   When defined, the line never idles. At any symbol boundary with no data
//   waiting, a K28.5 comma of the correct disparity is sent instead.
//   (COMMA_NEG when o_rdisp=0, COMMA_POS when o_rdisp=1.)
//   When undefined, the line drives low with o_active=0 between symbols.
//
// Parameters:
//   WORD_W     symbol width (10)
//   COMMA_NEG  K28.5 sent when running disparity is negative
//   COMMA_POS  K28.5 sent when running disparity is positive
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   i_word       encoded symbol
//   i_valid      i_word valid; a transfer occurs when i_valid & o_ready
//   o_ready      hold register empty (registered)
//   o_sdata      serial bit, registered
//   o_active     o_sdata carries a symbol bit (data or comma)
//   o_sym_start  high while o_sdata shows bit 'a'
//   o_rdisp      running disparity after the last loaded symbol (0 = RD-)
//   o_underrun   one-cycle pulse: a data symbol ended with no data waiting
// -----------------------------------------------------------------------------
module tx_serializer_10b #(
    parameter int                WORD_W    = 10,
    parameter logic [WORD_W-1:0] COMMA_NEG = 10'b0011111010,
    parameter logic [WORD_W-1:0] COMMA_POS = 10'b1100000101
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_sdata,
    output logic              o_active,
    output logic              o_sym_start,
    output logic              o_rdisp,
    output logic              o_underrun
);

    localparam int                CNT_W    = $clog2(WORD_W);
    localparam int                POP_W    = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_W - 1);
    localparam logic [POP_W:0]    WORD_CMP = (POP_W + 1)'(WORD_W);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // Registers
    state_t            r_state;
    logic [WORD_W-1:0] r_hold;
    logic              r_hold_vld;
    logic [WORD_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_rdisp;
    logic              r_underrun;
`ifdef COMMA_IDLE_EN
    // Set when the symbol currently on the line is data rather than a comma.
    // Only data -> comma transitions count as an underrun.
    logic              r_cur_data;
    logic              w_cur_data_next;
`endif

    // Next-state wires
    state_t            w_state_next;
    logic [WORD_W-1:0] w_hold_next;
    logic              w_hold_vld_next;
    logic [WORD_W-1:0] w_shift_next;
    logic [CNT_W-1:0]  w_bit_cnt_next;
    logic              w_rdisp_next;
    logic              w_underrun_next;

    // Datapath helpers
    logic              w_accept;
    logic              w_load;
    logic [WORD_W-1:0] w_load_sym;
    logic [POP_W-1:0]  w_ones;
    logic [POP_W:0]    w_ones_x2;

    function automatic logic [POP_W-1:0] popcount(input logic [WORD_W-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int k = 0; k < WORD_W; k++) begin
            n = n + POP_W'(v[k]);
        end
        return n;
    endfunction

    // A held data word always wins over a comma. Without the comma feature,
    // loads only happen with r_hold_vld set, so the comma leg is dead logic.
    assign w_load_sym = r_hold_vld ? r_hold : (r_rdisp ? COMMA_POS : COMMA_NEG);
    assign w_ones     = popcount(w_load_sym);
    assign w_ones_x2  = {w_ones, 1'b0};

    // The accept side sees only the registered o_ready. A drain and an accept
    // therefore never coincide on the same edge.
    assign w_accept = i_valid & ~r_hold_vld;

    always_comb begin
        w_state_next    = r_state;
        w_hold_next     = r_hold;
        w_hold_vld_next = r_hold_vld;
        w_shift_next    = r_shift;
        w_bit_cnt_next  = r_bit_cnt;
        w_rdisp_next    = r_rdisp;
        w_underrun_next = 1'b0;
        w_load          = 1'b0;
`ifdef COMMA_IDLE_EN
        w_cur_data_next = r_cur_data;
`endif

        case (r_state)
            S_IDLE: begin
`ifdef COMMA_IDLE_EN
                w_load = 1'b1;
`else
                w_load = r_hold_vld;
`endif
            end

            S_SHIFT: begin
                if (r_bit_cnt == LAST_BIT) begin
                    // Symbol boundary: chain the next symbol in without a gap.
                    if (r_hold_vld) begin
                        w_load = 1'b1;
                    end else begin
`ifdef COMMA_IDLE_EN
                        w_load          = 1'b1;
                        w_underrun_next = r_cur_data;
`else
                        w_state_next    = S_IDLE;
                        w_shift_next    = '0;
                        w_bit_cnt_next  = '0;
                        w_underrun_next = 1'b1;
`endif
                    end
                end else begin
                    w_shift_next   = {r_shift[WORD_W-2:0], 1'b0};
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_load) begin
            w_state_next   = S_SHIFT;
            w_shift_next   = w_load_sym;
            w_bit_cnt_next = '0;
`ifdef COMMA_IDLE_EN
            w_cur_data_next = r_hold_vld;
`endif
            // Balanced symbols leave the disparity where it was.
            if (w_ones_x2 > WORD_CMP) begin
                w_rdisp_next = 1'b1;
            end else if (w_ones_x2 < WORD_CMP) begin
                w_rdisp_next = 1'b0;
            end
        end

        if (w_load && r_hold_vld) begin
            w_hold_vld_next = 1'b0;
        end else if (w_accept) begin
            w_hold_vld_next = 1'b1;
            w_hold_next     = i_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_rdisp    <= 1'b0;
            r_underrun <= 1'b0;
`ifdef COMMA_IDLE_EN
            r_cur_data <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_hold     <= w_hold_next;
            r_hold_vld <= w_hold_vld_next;
            r_shift    <= w_shift_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_rdisp    <= w_rdisp_next;
            r_underrun <= w_underrun_next;
`ifdef COMMA_IDLE_EN
            r_cur_data <= w_cur_data_next;
`endif
        end
    end

    // Every output is a flop or a decode of flops. The shifter is cleared
    // whenever the line idles, so its MSB already reads 0 there.
    assign o_ready     = ~r_hold_vld;
    assign o_sdata     = r_shift[WORD_W-1];
    assign o_active    = (r_state == S_SHIFT);
    assign o_sym_start = (r_state == S_SHIFT) && (r_bit_cnt == '0);
    assign o_rdisp     = r_rdisp;
    assign o_underrun  = r_underrun;

endmodule

// File: tb/tb_tx_serializer_10b.sv
// -----------------------------------------------------------------------------
// tb_tx_serializer_10b
//
// Bench for tx_serializer_10b. A queue-based line model tracks the design
// every cycle. The model keeps the pending serial bits of the symbol on the
// line, the hold slot and the running disparity. Directed checks come from a
// vector table, from hand-written multi-cycle sequences, and from a
// randomized handshake phase.
// -----------------------------------------------------------------------------
module tb_tx_serializer_10b;

    localparam int         W    = 10;
    localparam logic [9:0] CNEG = 10'b0011111010;
    localparam logic [9:0] CPOS = 10'b1100000101;
`ifdef COMMA_IDLE_EN
    localparam bit COMMA_MODE = 1'b1;
`else
    localparam bit COMMA_MODE = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       i_valid = 1'b0;
    logic [9:0] i_word  = '0;
    logic       o_ready, o_sdata, o_active, o_sym_start, o_rdisp, o_underrun;
    logic [5:0] dut_out;

    always #5 clk = ~clk;

    tx_serializer_10b dut (
        .clk         (clk),
        .rst         (rst),
        .i_word      (i_word),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_sdata     (o_sdata),
        .o_active    (o_active),
        .o_sym_start (o_sym_start),
        .o_rdisp     (o_rdisp),
        .o_underrun  (o_underrun)
    );

    // {ready, sdata, active, sym_start, rdisp, underrun}
    assign dut_out = {o_ready, o_sdata, o_active, o_sym_start, o_rdisp, o_underrun};

    int n_vec = 0;
    int n_err = 0;

    task automatic check_v(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (ready,sdata,active,start,rdisp,underrun)",
                     name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bounded wait expired", name);
    endtask

    // ---------------- reference model ----------------
    bit         m_line[$];   // bits still to appear on the line; [0] is on the line now
    logic [9:0] m_hold;
    bit         m_hold_vld;
    bit         m_rd;
    bit         m_un;
    bit         m_cur_data;
    bit         m_init = 1'b0;

    task automatic model_load(input logic [9:0] sym, input bit is_data);
        int ones;
        for (int i = W - 1; i >= 0; i--) m_line.push_back(sym[i]);
        ones = $countones(sym);
        if (ones * 2 > W) m_rd = 1'b1;
        else if (ones * 2 < W) m_rd = 1'b0;
        m_cur_data = is_data;
    endtask

    task automatic model_edge(input logic r, input logic v, input logic [9:0] w);
        bit acc;
        bit had;
        if (r) begin
            m_line.delete();
            m_hold_vld = 1'b0;
            m_rd       = 1'b0;
            m_un       = 1'b0;
            m_cur_data = 1'b0;
            m_init     = 1'b1;
            return;
        end
        acc  = v && !m_hold_vld;
        m_un = 1'b0;
        had  = (m_line.size() != 0);
        if (had) void'(m_line.pop_front());
        if (m_line.size() == 0) begin
            if (m_hold_vld) begin
                model_load(m_hold, 1'b1);
                m_hold_vld = 1'b0;
            end else if (COMMA_MODE) begin
                if (had && m_cur_data) m_un = 1'b1;
                model_load(m_rd ? CPOS : CNEG, 1'b0);
            end else if (had) begin
                m_un = 1'b1;
            end
        end
        if (acc) begin
            m_hold     = w;
            m_hold_vld = 1'b1;
        end
    endtask

    function automatic logic [5:0] model_out();
        logic sd;
        sd = (m_line.size() != 0) ? m_line[0] : 1'b0;
        return {!m_hold_vld, sd, m_line.size() != 0, m_line.size() == W, m_rd, m_un};
    endfunction

    // Model step and comparison on every clock edge.
    initial begin
        logic       r, v;
        logic [9:0] w;
        forever begin
            @(posedge clk);
            r = rst;
            v = i_valid;
            w = i_word;
            #1;
            model_edge(r, v, w);
            if (m_init) check_v("model", dut_out, model_out());
        end
    end

    // Event counters used by the back-to-back sequence.
    bit cnt_en = 1'b0;
    int c_act, c_ss, c_un, c_runs;
    bit c_prev_act, c_un_early;
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (cnt_en) begin
                if (o_active) c_act++;
                if (o_active && !c_prev_act) c_runs++;
                if (o_sym_start) c_ss++;
                if (o_underrun) begin
                    c_un++;
                    if (c_ss < 3) c_un_early = 1'b1;
                end
                c_prev_act = o_active;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [9:0] w);
        int t;
        t = 0;
        @(negedge clk);
        while (!o_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!o_ready) fail_now("send_word_ready");
        i_valid = 1'b1;
        i_word  = w;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic send_burst(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        logic [9:0] ws[3];
        ws = '{a, b, c};
        @(negedge clk);
        i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int t;
            t      = 0;
            i_word = ws[k];
            while (!o_ready && t < 60) begin
                @(negedge clk);
                t++;
            end
            if (!o_ready) fail_now("burst_ready");
            @(negedge clk);
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_sym_start(input string name);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 40 && !ok; t++) begin
            step();
            if (o_sym_start) ok = 1'b1;
        end
        if (!ok) fail_now(name);
    endtask

    typedef struct {
        logic       rst;
        logic       valid;
        logic [9:0] word;
        logic [5:0] exp;
    } vec_t;

    vec_t       tbl[14];
    logic [9:0] w1;
    logic [9:0] wa, wb, wc;
    logic [19:0] cpat;
    bit         any_act;
    bit         last_acc;

    initial begin
        // ---- vector table: single symbol after reset ----
        w1     = 10'b1001110100;
        tbl[0] = '{1'b1, 1'b0, 10'd0, 6'b100000};
        tbl[1] = '{1'b0, 1'b1, w1,    6'b000000};
        tbl[2] = '{1'b0, 1'b0, 10'd0, 6'b111100};
        for (int i = 0; i < 9; i++)
            tbl[3 + i] = '{1'b0, 1'b0, 10'd0, {1'b1, w1[8 - i], 1'b1, 1'b0, 1'b0, 1'b0}};
        tbl[12] = '{1'b0, 1'b0, 10'd0, 6'b100001};
        tbl[13] = '{1'b0, 1'b0, 10'd0, 6'b100000};

`ifndef COMMA_IDLE_EN
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            rst     = tbl[i].rst;
            i_valid = tbl[i].valid;
            i_word  = tbl[i].word;
            step();
            check_v($sformatf("tbl[%0d]", i), dut_out, tbl[i].exp);
        end

        // ---- disparity tracking ----
        send_word(10'b1100000101);
        wait_sym_start("rd_wait0");
        check_b("rd_4ones", o_rdisp, 1'b0);
        send_word(10'b0011111010);
        wait_sym_start("rd_wait1");
        check_b("rd_6ones", o_rdisp, 1'b1);
        send_word(10'b1010101010);
        wait_sym_start("rd_wait2");
        check_b("rd_bal_hold1", o_rdisp, 1'b1);
        send_word(10'b1100000101);
        wait_sym_start("rd_wait3");
        check_b("rd_4ones_b", o_rdisp, 1'b0);
        send_word(10'b0101010101);
        wait_sym_start("rd_wait4");
        check_b("rd_bal_hold0", o_rdisp, 1'b0);
        repeat (15) @(posedge clk);

        // ---- three symbols back-to-back ----
        @(negedge clk);
        c_act = 0; c_ss = 0; c_un = 0; c_runs = 0;
        c_prev_act = 1'b0; c_un_early = 1'b0;
        cnt_en = 1'b1;
        send_burst(10'($urandom), 10'($urandom), 10'($urandom));
        repeat (30) @(posedge clk);
        @(negedge clk);
        cnt_en = 1'b0;
        check_i("b2b_active_cycles", c_act, 30);
        check_i("b2b_runs", c_runs, 1);
        check_i("b2b_sym_starts", c_ss, 3);
        check_i("b2b_underruns", c_un, 1);
        check_b("b2b_underrun_early", c_un_early, 1'b0);

        // ---- reset in the middle of a symbol with the hold full ----
        wa = 10'b1110001100;
        wb = 10'b0110110011;
        wc = 10'b1011000110;
        send_word(wa);
        wait_sym_start("rst_wait_a");
        send_word(wb);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_b("pre_rst_bit4", o_sdata, wa[5]);
        check_b("pre_rst_hold_full", o_ready, 1'b0);
        rst = 1'b1;
        step();
        check_v("mid_rst_outputs", dut_out, 6'b100000);
        @(negedge clk);
        rst     = 1'b0;
        any_act = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (o_active) any_act = 1'b1;
        end
        check_b("rst_hold_discarded", any_act, 1'b0);
        send_word(wc);
        wait_sym_start("rst_wait_c");
        check_b("post_rst_bit0", o_sdata, wc[9]);
        for (int i = 1; i < 10; i++) begin
            step();
            check_b($sformatf("post_rst_bit%0d", i), o_sdata, wc[9 - i]);
        end
        step();
        check_b("post_rst_underrun", o_underrun, 1'b1);
`else
        // ---- comma fill after reset ----
        cpat = {CNEG, CPOS};
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check_b($sformatf("comma_bit%0d", i), o_sdata, cpat[19 - i]);
            check_b($sformatf("comma_act%0d", i), o_active, 1'b1);
        end
        send_word(10'b1001110100);
        wait_sym_start("comma_data_wait");
`endif

        // ---- randomized handshake against the model ----
        last_acc = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            rst = 1'b0;
            if ($urandom_range(0, 399) == 0) rst = 1'b1;
            if (!i_valid || last_acc) begin
                // Alternate dense and sparse phases so both gap-free chaining
                // and idle/underrun paths are exercised.
                if ((cyc / 200) % 2 == 0) i_valid = ($urandom_range(0, 3) != 0);
                else                      i_valid = ($urandom_range(0, 15) == 0);
                i_word = 10'($urandom);
            end
            last_acc = i_valid && o_ready && !rst;
        end
        @(negedge clk);
        rst     = 1'b0;
        i_valid = 1'b0;
        repeat (25) @(posedge clk);
        #4;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
